uart_rx_param: RTL

Parametrised UART receiver, successor to the fixed 8-bit, one-sample-per-clock receiver. It adds:
- a baud-rate divider with mid-bit sampling
- a configurable data width
- start-glitch rejection and stop-bit checking
- a valid/ready output handshake with overrun detection
- optional parity

It sits between the board RX pin and downstream consumers (command decoder, FIFO).

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_cnt.sv | 31 +++
 rtl/uart_rx_param.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: FSM state encodings,
// the default bit period and a constant clog2 helper.
package uart_pkg;

    localparam int DEF_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: tick_o on the last clock of a bit, half_o at mid-bit.
// clr_i restarts the period from zero on the next clock.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o,
    output logic half_o
);
    localparam int W = clog2(CLKS_PER_BIT);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == W'(CLKS_PER_BIT - 1));
    assign half_o = (cnt_q == W'(CLKS_PER_BIT / 2 - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop sync, mid-bit sampling, valid/ready output.
// Define UART_RX_PARITY_EN to add a parity bit (even, or odd with PARITY_ODD=1).
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int BW = clog2(DATA_BITS);

    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_rx_param: illegal parameter combination");
    end

    uart_state_e          state_q, state_d;
    logic [1:0]           sync_q;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_s, tick, half, baud_clr, done;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    assign rx_s = sync_q[1];
    // Restarting the period on every state change keeps later samples mid-bit.
    assign baud_clr = (state_d != state_q) || (state_q == ST_IDLE);

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (baud_clr),
        .tick_o (tick),
        .half_o (half)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        done        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (half) state_d = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    par_bad_d = ((^shift_q) ^ (PARITY_ODD != 0)) != rx_s;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    done = 1'b1;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A word still waiting with no consumer this cycle wins; the new one is lost.
        if (done) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = shift_d;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sync_q      <= 2'b11;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], rx};
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
